cenn_window_stage: RTL and testbench

Parametrised dual-stream window generator for an iterated CeNN processing element. It accepts a raster-order input stream `u` and a previous-iteration state stream `y`, buffers both through shared line buffers, and emits aligned 3x3 `u` and `y` windows. Each window carries its centre coordinates, frame flags and a selectable boundary condition. It sits between the fixed-point converter (or the previous PE stage) and the neuron datapath, replacing the single-stream, unbounded-frame window path.

---
 rtl/cenn_pkg.sv | 31 +++
 rtl/cenn_line_buffer.sv | 43 ++++
 rtl/cenn_window_stage.sv | 271 +++++++++++++++++++++++++++
 tb/tb_cenn_window_stage.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cenn_pkg.sv
// Shared types and constants for the CeNN window stage.
//   bnd_mode_t : boundary condition selector (Dirichlet / zero-flux)
//   win_state_t: window stage sequencing states (RUN / DRAIN)
//   W_*        : element indices inside a flattened 3x3 window,
//                k = 3*(row offset + 1) + (col offset + 1)
package cenn_pkg;

    localparam int DEF_WIDTH          = 15;
    localparam int DEF_BIT_FRACTIONAL = 9;

    typedef enum logic {
        BND_DIRICHLET = 1'b0,
        BND_ZEROFLUX  = 1'b1
    } bnd_mode_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } win_state_t;

    localparam int W_NW = 0;
    localparam int W_N  = 1;
    localparam int W_NE = 2;
    localparam int W_W  = 3;
    localparam int W_C  = 4;
    localparam int W_E  = 5;
    localparam int W_SW = 6;
    localparam int W_S  = 7;
    localparam int W_SE = 8;

endpackage

// File: rtl/cenn_line_buffer.sv
// Circular line buffer: one read and one write per enabled cycle.
// The read port shows the word written DEPTH enables ago (combinational
// read at the current pointer, so the caller sees it in the same step
// that overwrites it).
//   clk, rst  : clock, async active-high reset (pointer only; RAM not cleared)
//   en        : advance (write wr_data, move pointer)
//   wr_data   : word entering the buffer
//   rd_data   : word leaving the buffer (DEPTH steps old)
module cenn_line_buffer
    import cenn_pkg::*;
#(
    parameter int WIDTH = 2 * DEF_WIDTH,
    parameter int DEPTH = 1024
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr;

    assign rd_data = mem[ptr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
        end
    end

endmodule

// File: rtl/cenn_window_stage.sv
// Dual-stream 3x3 window generator for an iterated CeNN processing element.
// Buffers raster-ordered u and y streams through two shared line buffers
// and emits aligned u/y windows with centre coordinates, frame flags and
// boundary substitution.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_RUN   | accepting pixels; each transfer is a step
// ST_DRAIN | in_ready low for COLS+1 cycles, each cycle a step that flushes
//          | the last row's windows out of the line buffers
//
// Ports:
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : input handshake
//   u_in, y_in          : input pixel and state pixel at the same position
//   bnd_mode, bnd_value : boundary condition, latched with pixel (0,0)
//   out_valid           : window valid (no backpressure)
//   u_win, y_win        : 3x3 windows, element k at [k*WIDTH +: WIDTH]
//   out_row, out_col    : window centre position
//   out_sof, out_eof    : centre is first / last pixel of the frame
module cenn_window_stage
    import cenn_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int BIT_FRACTIONAL = DEF_BIT_FRACTIONAL,
    parameter int COLS           = 1024,
    parameter int ROWS           = 768
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        u_in,
    input  logic [WIDTH-1:0]        y_in,
    input  logic                    bnd_mode,
    input  logic [WIDTH-1:0]        bnd_value,
    output logic                    out_valid,
    output logic [9*WIDTH-1:0]      u_win,
    output logic [9*WIDTH-1:0]      y_win,
    output logic [$clog2(ROWS)-1:0] out_row,
    output logic [$clog2(COLS)-1:0] out_col,
    output logic                    out_sof,
    output logic                    out_eof
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int DW = $clog2(COLS + 1);
    localparam int FW = $clog2(COLS + 2);

    if (COLS < 3 || ROWS < 3) begin : g_bad_size
        $error("cenn_window_stage: COLS and ROWS must be at least 3");
    end
    if (BIT_FRACTIONAL >= WIDTH) begin : g_bad_frac
        $error("cenn_window_stage: BIT_FRACTIONAL must be below WIDTH");
    end

    win_state_t       state;
    logic [RW-1:0]    irow;
    logic [CW-1:0]    icol;
    logic [DW-1:0]    drain_cnt;
    logic [FW-1:0]    fill_cnt;
    logic [RW-1:0]    orow;
    logic [CW-1:0]    ocol;
    bnd_mode_t        lat_mode;
    logic [WIDTH-1:0] lat_value;

    logic             step;
    logic [2*WIDTH-1:0] lb1_rd;
    logic [2*WIDTH-1:0] lb2_rd;

    // Two stored columns per stream; the third (rightmost) window column is
    // the live column formed by the line buffer taps and the incoming pixel.
    logic [WIDTH-1:0] u_sr [3][2];
    logic [WIDTH-1:0] y_sr [3][2];
    logic [WIDTH-1:0] col_u [3];
    logic [WIDTH-1:0] col_y [3];
    logic [9*WIDTH-1:0] raw_u;
    logic [9*WIDTH-1:0] raw_y;

    logic at_l, at_r, at_t, at_b;

    assign step = (state == ST_RUN) ? in_valid : 1'b1;

    cenn_line_buffer #(.WIDTH(2 * WIDTH), .DEPTH(COLS)) u_lb_r1 (
        .clk     (clk),
        .rst     (rst),
        .en      (step),
        .wr_data ({y_in, u_in}),
        .rd_data (lb1_rd)
    );

    cenn_line_buffer #(.WIDTH(2 * WIDTH), .DEPTH(COLS)) u_lb_r2 (
        .clk     (clk),
        .rst     (rst),
        .en      (step),
        .wr_data (lb1_rd),
        .rd_data (lb2_rd)
    );

    always_comb begin
        col_u[0] = lb2_rd[WIDTH-1:0];
        col_u[1] = lb1_rd[WIDTH-1:0];
        col_u[2] = u_in;
        col_y[0] = lb2_rd[2*WIDTH-1:WIDTH];
        col_y[1] = lb1_rd[2*WIDTH-1:WIDTH];
        col_y[2] = y_in;
        raw_u = '0;
        raw_y = '0;
        for (int r = 0; r < 3; r++) begin
            raw_u[(3*r)*WIDTH   +: WIDTH] = u_sr[r][0];
            raw_u[(3*r+1)*WIDTH +: WIDTH] = u_sr[r][1];
            raw_u[(3*r+2)*WIDTH +: WIDTH] = col_u[r];
            raw_y[(3*r)*WIDTH   +: WIDTH] = y_sr[r][0];
            raw_y[(3*r+1)*WIDTH +: WIDTH] = y_sr[r][1];
            raw_y[(3*r+2)*WIDTH +: WIDTH] = col_y[r];
        end
    end

    // The output counters point at the centre of the window about to be
    // emitted, so they select the boundary substitution directly.
    assign at_l = (ocol == '0);
    assign at_r = (ocol == CW'(COLS - 1));
    assign at_t = (orow == '0);
    assign at_b = (orow == RW'(ROWS - 1));

    // Columns are resolved before rows so a replicated corner takes the
    // already-clamped edge value.
    function automatic logic [9*WIDTH-1:0] bnd_mux(
        input logic [9*WIDTH-1:0] raw,
        input logic               l,
        input logic               rt,
        input logic               t,
        input logic               b,
        input bnd_mode_t          mode,
        input logic [WIDTH-1:0]   val
    );
        logic [WIDTH-1:0]   e [9];
        logic               dir;
        logic [9*WIDTH-1:0] res;
        dir = (mode == BND_DIRICHLET);
        for (int k = 0; k < 9; k++) begin
            e[k] = raw[k*WIDTH +: WIDTH];
        end
        if (l) begin
            e[W_NW] = dir ? val : e[W_N];
            e[W_W]  = dir ? val : e[W_C];
            e[W_SW] = dir ? val : e[W_S];
        end
        if (rt) begin
            e[W_NE] = dir ? val : e[W_N];
            e[W_E]  = dir ? val : e[W_C];
            e[W_SE] = dir ? val : e[W_S];
        end
        if (t) begin
            e[W_NW] = dir ? val : e[W_W];
            e[W_N]  = dir ? val : e[W_C];
            e[W_NE] = dir ? val : e[W_E];
        end
        if (b) begin
            e[W_SW] = dir ? val : e[W_W];
            e[W_S]  = dir ? val : e[W_C];
            e[W_SE] = dir ? val : e[W_E];
        end
        res = '0;
        for (int k = 0; k < 9; k++) begin
            res[k*WIDTH +: WIDTH] = e[k];
        end
        return res;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            in_ready  <= 1'b1;
            irow      <= '0;
            icol      <= '0;
            drain_cnt <= '0;
            fill_cnt  <= FW'(COLS + 1);
            orow      <= '0;
            ocol      <= '0;
            lat_mode  <= BND_DIRICHLET;
            lat_value <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            u_win     <= '0;
            y_win     <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 2; c++) begin
                    u_sr[r][c] <= '0;
                    y_sr[r][c] <= '0;
                end
            end
        end else begin
            out_valid <= 1'b0;

            case (state)
                ST_RUN: begin
                    if (in_valid) begin
                        if (irow == '0 && icol == '0) begin
                            lat_mode  <= bnd_mode_t'(bnd_mode);
                            lat_value <= bnd_value;
                        end
                        if (icol == CW'(COLS - 1)) begin
                            icol <= '0;
                            if (irow == RW'(ROWS - 1)) begin
                                irow      <= '0;
                                state     <= ST_DRAIN;
                                in_ready  <= 1'b0;
                                drain_cnt <= DW'(COLS);
                            end else begin
                                irow <= irow + RW'(1);
                            end
                        end else begin
                            icol <= icol + CW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state    <= ST_RUN;
                        in_ready <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    in_ready <= 1'b1;
                end
            endcase

            if (step) begin
                for (int r = 0; r < 3; r++) begin
                    u_sr[r][0] <= u_sr[r][1];
                    u_sr[r][1] <= col_u[r];
                    y_sr[r][0] <= y_sr[r][1];
                    y_sr[r][1] <= col_y[r];
                end

                // The first COLS+1 steps of a frame only fill the pipeline.
                if (fill_cnt != '0) begin
                    fill_cnt <= fill_cnt - FW'(1);
                end else begin
                    out_valid <= 1'b1;
                    u_win     <= bnd_mux(raw_u, at_l, at_r, at_t, at_b, lat_mode, lat_value);
                    y_win     <= bnd_mux(raw_y, at_l, at_r, at_t, at_b, lat_mode, lat_value);
                    out_row   <= orow;
                    out_col   <= ocol;
                    out_sof   <= at_t && at_l;
                    out_eof   <= at_b && at_r;
                    if (at_r) begin
                        ocol <= '0;
                        if (at_b) begin
                            orow     <= '0;
                            fill_cnt <= FW'(COLS + 1);
                        end else begin
                            orow <= orow + RW'(1);
                        end
                    end else begin
                        ocol <= ocol + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cenn_window_stage.sv
module tb_cenn_window_stage;

    localparam int W = 15;
    localparam int C = 4;
    localparam int R = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   u_in;
    logic [W-1:0]   y_in;
    logic           bnd_mode;
    logic [W-1:0]   bnd_value;
    logic           out_valid;
    logic [9*W-1:0] u_win;
    logic [9*W-1:0] y_win;
    logic [1:0]     out_row;
    logic [1:0]     out_col;
    logic           out_sof;
    logic           out_eof;

    cenn_window_stage #(
        .WIDTH(W), .BIT_FRACTIONAL(9), .COLS(C), .ROWS(R)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .u_in      (u_in),
        .y_in      (y_in),
        .bnd_mode  (bnd_mode),
        .bnd_value (bnd_value),
        .out_valid (out_valid),
        .u_win     (u_win),
        .y_win     (y_win),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_sof   (out_sof),
        .out_eof   (out_eof)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9*W-1:0] u;
        logic [9*W-1:0] y;
        logic [1:0]     row;
        logic [1:0]     col;
        logic           sof;
        logic           eof;
    } exp_t;

    exp_t           exp_q[$];
    int             n_cmp = 0;
    int             n_fail = 0;
    int             cyc = 0;
    int             win_cnt = 0;
    bit             first_seen = 0;
    int             first_cyc = 0;
    bit             prev_step = 0;
    logic [9*W-1:0] cap_u [12];
    logic [9*W-1:0] cap_y [12];
    logic           cap_sof [12];
    logic           cap_eof [12];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference pixel: direct 2D lookup with out-of-frame handling.
    function automatic int ref_px(input int r, input int c, input bit zf, input int bval, input int off);
        int rr;
        int cc;
        rr = r;
        cc = c;
        if (r < 0 || r >= R || c < 0 || c >= C) begin
            if (!zf) return bval;
            rr = (r < 0) ? 0 : (r >= R) ? R - 1 : r;
            cc = (c < 0) ? 0 : (c >= C) ? C - 1 : c;
        end
        return 1 + rr * C + cc + off;
    endfunction

    function automatic void push_frame(input bit zf, input int bval);
        exp_t e;
        int   v;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                for (int k = 0; k < 9; k++) begin
                    v = ref_px(r + k / 3 - 1, c + k % 3 - 1, zf, bval, 0);
                    e.u[k*W +: W] = v[W-1:0];
                    v = ref_px(r + k / 3 - 1, c + k % 3 - 1, zf, bval, 100);
                    e.y[k*W +: W] = v[W-1:0];
                end
                v = r; e.row = v[1:0];
                v = c; e.col = v[1:0];
                e.sof = (r == 0 && c == 0);
                e.eof = (r == R - 1 && c == C - 1);
                exp_q.push_back(e);
            end
        end
    endfunction

    function automatic logic [9*W-1:0] pack9(input int e0, input int e1, input int e2,
                                             input int e3, input int e4, input int e5,
                                             input int e6, input int e7, input int e8);
        int             a [9];
        logic [9*W-1:0] res;
        int             v;
        a[0] = e0; a[1] = e1; a[2] = e2; a[3] = e3; a[4] = e4;
        a[5] = e5; a[6] = e6; a[7] = e7; a[8] = e8;
        res = '0;
        for (int k = 0; k < 9; k++) begin
            v = a[k];
            res[k*W +: W] = v[W-1:0];
        end
        return res;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin : monitor
        exp_t e;
        int   idx;
        if (rst) begin
            prev_step = 0;
        end else begin
            if (out_valid) begin
                chk("valid_has_step", prev_step, 1);
                win_cnt++;
                if (!first_seen) begin
                    first_seen = 1;
                    first_cyc  = cyc;
                end
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_window: row %0d col %0d, none expected", out_row, out_col);
                end else begin
                    e = exp_q.pop_front();
                    chk("u_win", u_win, e.u);
                    chk("y_win", y_win, e.y);
                    chk("pos_flags", {out_row, out_col, out_sof, out_eof}, {e.row, e.col, e.sof, e.eof});
                    idx = int'(e.row) * C + int'(e.col);
                    cap_u[idx]   = u_win;
                    cap_y[idx]   = y_win;
                    cap_sof[idx] = out_sof;
                    cap_eof[idx] = out_eof;
                end
            end
            prev_step = (in_valid && in_ready) || !in_ready;
        end
    end

    task automatic send(input int idx, input bit gap, output int waits, output int xcyc);
        int v;
        int g;
        bit ok;
        if (gap) begin
            g = $urandom_range(0, 1);
            repeat (g) begin
                in_valid = 0;
                @(posedge clk); #1;
            end
        end
        v = idx + 1;   u_in = v[W-1:0];
        v = idx + 101; y_in = v[W-1:0];
        in_valid = 1;
        waits = 0;
        xcyc  = 0;
        ok    = 0;
        while (!ok) begin
            @(negedge clk);
            ok   = in_ready;
            xcyc = cyc;
            @(posedge clk); #1;
            if (!ok) begin
                waits++;
                if (waits > 50) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL send_timeout: in_ready low %0d cycles, required at most 50", waits);
                    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
                    $fatal(1, "input stalled");
                end
            end
        end
        in_valid = 0;
    endtask

    task automatic send_frame(input bit gap, input bit toggle, output int first_wait, output int x6);
        int w;
        int xc;
        first_wait = 0;
        x6 = 0;
        for (int i = 0; i < R * C; i++) begin
            send(i, gap, w, xc);
            if (i == 0) first_wait = w;
            if (i == 5) x6 = xc;
            if (toggle && i == 2) begin
                bnd_mode  = 1'b1;
                bnd_value = 15'd99;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        in_valid = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_idle: %0d windows outstanding after 200 cycles, required 0", exp_q.size());
        end
    endtask

    initial begin
        int w0;
        int w1;
        int x6;
        int dummy;
        rst = 1; in_valid = 0; u_in = '0; y_in = '0; bnd_mode = 0; bnd_value = '0;

        #12;
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sof_eof",   {out_sof, out_eof}, 0);
        chk("rst_row_col",   {out_row, out_col}, 0);
        chk("rst_u_win",     u_win, 0);
        chk("rst_y_win",     y_win, 0);
        #10 rst = 0;
        @(posedge clk); #1;

        // Continuous, two back-to-back Dirichlet(0) frames
        win_cnt = 0;
        push_frame(0, 0);
        push_frame(0, 0);
        send_frame(0, 0, w0, x6);
        chk("first_pixel_wait", w0, 0);
        send_frame(0, 0, w1, dummy);
        chk("drain_ready_low", w1, 5);
        wait_idle();
        chk("first_window_latency", first_cyc, x6 + 1);
        chk("windows_two_frames", win_cnt, 24);
        chk("hand_dir0_u_c1",  cap_u[0], pack9(0, 0, 0, 0, 1, 2, 0, 5, 6));
        chk("hand_dir0_y_c1",  cap_y[0], pack9(0, 0, 0, 0, 101, 102, 0, 105, 106));
        chk("hand_dir0_sof",   cap_sof[0], 1);
        chk("hand_dir0_u_c7",  cap_u[6], pack9(2, 3, 4, 6, 7, 8, 10, 11, 12));

        // Gapped Dirichlet(0) frame
        win_cnt = 0;
        push_frame(0, 0);
        send_frame(1, 0, w0, dummy);
        wait_idle();
        chk("windows_gapped", win_cnt, 12);
        chk("hand_gap_u_c7", cap_u[6], pack9(2, 3, 4, 6, 7, 8, 10, 11, 12));

        // Dirichlet(7) frame with mode/value changed after transfer 3
        bnd_mode = 0; bnd_value = 15'd7;
        win_cnt = 0;
        push_frame(0, 7);
        send_frame(1, 1, w0, dummy);
        wait_idle();
        chk("windows_dir7", win_cnt, 12);
        chk("hand_dir7_u_c1",  cap_u[0],  pack9(7, 7, 7, 7, 1, 2, 7, 5, 6));
        chk("hand_dir7_u_c12", cap_u[11], pack9(7, 8, 7, 11, 12, 7, 7, 7, 7));

        // Next frame picks up zero-flux
        win_cnt = 0;
        push_frame(1, 99);
        send_frame(1, 0, w0, dummy);
        wait_idle();
        chk("windows_zf", win_cnt, 12);
        chk("hand_zf_u_c1",  cap_u[0],  pack9(1, 1, 2, 1, 1, 2, 5, 5, 6));
        chk("hand_zf_u_c12", cap_u[11], pack9(7, 8, 8, 11, 12, 12, 11, 12, 12));
        chk("hand_zf_y_c12", cap_y[11], pack9(107, 108, 108, 111, 112, 112, 111, 112, 112));
        chk("hand_zf_eof",   cap_eof[11], 1);

        // Reset after 7 transfers
        bnd_mode = 0; bnd_value = '0;
        push_frame(0, 0);
        for (int i = 0; i < 7; i++) send(i, 0, w0, dummy);
        chk("pre_reset_valid", out_valid, 1);
        #1 rst = 1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_ready", in_ready, 1);
        chk("async_rst_u_win", u_win, 0);
        chk("async_rst_pos",   {out_row, out_col, out_sof, out_eof}, 0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #3 rst = 0;
        @(posedge clk); #1;
        win_cnt = 0;
        push_frame(0, 0);
        send_frame(0, 0, w0, dummy);
        wait_idle();
        chk("windows_after_reset", win_cnt, 12);
        chk("hand_rst_u_c1", cap_u[0], pack9(0, 0, 0, 0, 1, 2, 0, 5, 6));
        chk("hand_rst_y_c1", cap_y[0], pack9(0, 0, 0, 0, 101, 102, 0, 105, 106));
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
